banco_registros: RTL and testbench
==================================

Name: banco_registros

Overview:
- Parametrised bank of CHANNELS registers, each WIDTH bits, with an atomic snapshot (shadow) copy and per-channel dirty tracking.
- Sits between the RTC bus controller and the display/format logic.
- The controller writes time/date/timer fields into the live bank.
- The display side reads a coherent shadow copy captured on a single `snap` pulse, so it never shows a half-updated time.

Parameters:
- WIDTH, 8, data width of each channel register.
- CHANNELS, 9, number of channel registers (seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora).
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= CHANNELS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_req  input  1  write request, level; sampled each clk.
- wr_addr  input  ADDR_W  write channel index.
- data_in  input  WIDTH  write data.
- wr_ack  output  1  one-cycle pulse acknowledging an accepted write.
- wr_err  output  1  one-cycle pulse when wr_req targets addr >= CHANNELS.
- snap  input  1  capture live bank into shadow bank.
- rd_addr  input  ADDR_W  read channel index.
- sel_shadow  input  1  1 = read shadow bank, 0 = read live bank.
- data_out  output  WIDTH  registered read data.
- dirty  output  CHANNELS  bit i set when channel i was written since the last snap.

Behaviour:
- Reset (reset_n=0, asynchronous, takes effect immediately):
  - All live and shadow registers = 0.
  - data_out = 0, wr_ack = 0, wr_err = 0, dirty = 0.
  - Release is synchronous to the next clk edge.
- Write path, two states, registered:
  - IDLE: on wr_req=1 with wr_addr < CHANNELS:
    - live[wr_addr] <= data_in.
    - dirty[wr_addr] <= 1.
    - wr_ack = 1 in the following cycle.
    - Go to ACK.
  - IDLE: on wr_req=1 with wr_addr >= CHANNELS:
    - No register changes.
    - wr_err = 1 in the following cycle.
    - Go to ACK.
  - ACK: wr_ack and wr_err return to 0.
    - Stay in ACK while wr_req=1; return to IDLE when wr_req=0.
    - Result: exactly one write per request assertion. A held wr_req never writes twice.
  - Reset in ACK returns to IDLE.
- Snapshot:
  - On a clk edge with snap=1, shadow[i] <= live[i] for all i in the same cycle, and dirty <= 0.
  - snap held high captures every cycle; there is no edge detect.
- Simultaneous write and snap on the same edge:
  - Shadow captures the pre-write live value.
  - Live takes the new value.
  - dirty[wr_addr] ends at 1, because set has priority over snap-clear for that bit; all other bits clear.
- Read path:
  - data_out <= (sel_shadow ? shadow[rd_addr] : live[rd_addr]) every clk edge. Latency is 1 cycle.
  - rd_addr >= CHANNELS returns 0.
  - Reading the live bank at the address being written in the same cycle returns the old value (read-before-write). The new value appears one cycle later.
- Widths:
  - No arithmetic; data is stored verbatim.
  - wr_addr and rd_addr are compared unsigned against CHANNELS.

Decomposition:
- Shared package banco_pkg holds:
  - Channel index constants: CH_SEG=0, CH_MIN=1, CH_HORA=2, CH_DIA=3, CH_MES=4, CH_ANIO=5, CH_TSEG=6, CH_TMIN=7, CH_THORA=8.
  - Default WIDTH, CHANNELS, ADDR_W.
  - Write-FSM state encoding: IDLE, ACK.
- Natural sub-module: registro_en, a WIDTH-parametrised register with load enable and asynchronous active-low reset.
  - Instantiated 2×CHANNELS times, once per live register and once per shadow register.

Test Plan:
1. Reset mid-operation:
   - Write 0x59 to ch0, assert reset_n=0 for 1 cycle while wr_ack is high.
   - Required: data_out=0, dirty=0, wr_ack=0 immediately; live ch0 reads 0x00 after release.
2. Single write and acknowledge:
   - wr_req=1, wr_addr=1, data_in=0x45, held 4 cycles.
   - Required: wr_ack pulses exactly once, cycle 2; live ch1 = 0x45; dirty = 9'b000000010.
3. Snapshot coherence:
   - Write ch0=0x30, ch1=0x12, pulse snap, then write ch0=0x31.
   - Required: shadow ch0 reads 0x30 with sel_shadow=1; live ch0 reads 0x31; dirty = 9'b000000001.
4. Simultaneous write and snap:
   - Live ch2=0x08; on the same edge, wr_req for ch2=0x09 and snap=1.
   - Required: shadow ch2=0x08, live ch2=0x09, dirty[2]=1, all other dirty bits 0.
5. Out-of-range access:
   - wr_addr=12, data_in=0xFF.
   - Required: wr_err pulses once, wr_ack stays 0, no channel changes, dirty unchanged.
   - rd_addr=12 returns data_out=0x00.
6. Read-before-write:
   - rd_addr=3, sel_shadow=0, live ch3=0x15; write ch3=0x16.
   - Required: data_out=0x15 on the write edge and 0x16 one cycle later.

Source files
------------

// File: rtl/banco_pkg.sv
// ============================================================================
// banco_pkg : shared constants for the RTC register bank
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package banco_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 9;
  localparam int DEF_ADDR_W   = 4;

  localparam int CH_SEG   = 0;
  localparam int CH_MIN   = 1;
  localparam int CH_HORA  = 2;
  localparam int CH_DIA   = 3;
  localparam int CH_MES   = 4;
  localparam int CH_ANIO  = 5;
  localparam int CH_TSEG  = 6;
  localparam int CH_TMIN  = 7;
  localparam int CH_THORA = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;
endpackage

`default_nettype wire

// File: rtl/registro_en.sv
// ============================================================================
// registro_en : WIDTH-bit register with load enable, async active-low reset
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module registro_en
  import banco_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (en) val_d = d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) val_q <= '0;
    else          val_q <= val_d;
  end

  assign q = val_q;

endmodule

`default_nettype wire

// File: rtl/banco_registros.sv
// ============================================================================
// banco_registros : live register bank with atomic shadow snapshot and dirty
//                   tracking, between the RTC bus controller and the display
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module banco_registros
  import banco_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    data_in,
  output logic                wr_ack,
  output logic                wr_err,
  input  logic                snap,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                sel_shadow,
  output logic [WIDTH-1:0]    data_out,
  output logic [CHANNELS-1:0] dirty
);

  logic [0:0]          state_d, state_q;
  logic                wr_ack_d, wr_ack_q;
  logic                wr_err_d, wr_err_q;
  logic [CHANNELS-1:0] dirty_d, dirty_q;
  logic [WIDTH-1:0]    data_out_d, data_out_q;

  logic [WIDTH-1:0]    live   [CHANNELS];
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic                wr_in_range;
  logic                wr_fire;

  assign wr_in_range = (32'(wr_addr) < 32'(CHANNELS));
  // Only IDLE accepts a request, so a held wr_req writes once.
  assign wr_fire     = (state_q == ST_IDLE) && wr_req && wr_in_range;

  // Shadow loads from the pre-edge live value, so a same-edge write is not seen.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    registro_en #(.WIDTH(WIDTH)) u_live (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (wr_fire && (wr_addr == ADDR_W'(i))),
      .d       (data_in),
      .q       (live[i])
    );
    registro_en #(.WIDTH(WIDTH)) u_shadow (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (snap),
      .d       (live[i]),
      .q       (shadow[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wr_req)  state_d = ST_ACK;
      ST_ACK:  if (!wr_req) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ack_d = wr_fire;
    wr_err_d = (state_q == ST_IDLE) && wr_req && !wr_in_range;
  end

  // Set wins over snap-clear for the channel being written.
  always_comb begin
    dirty_d = snap ? '0 : dirty_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_fire && (wr_addr == ADDR_W'(i))) dirty_d[i] = 1'b1;
    end
  end

  always_comb begin
    data_out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_addr == ADDR_W'(i)) data_out_d = sel_shadow ? shadow[i] : live[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      dirty_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ack_q   <= wr_ack_d;
      wr_err_q   <= wr_err_d;
      dirty_q    <= dirty_d;
      data_out_q <= data_out_d;
    end
  end

  assign wr_ack   = wr_ack_q;
  assign wr_err   = wr_err_q;
  assign dirty    = dirty_q;
  assign data_out = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_banco_registros.sv
// ============================================================================
// tb_banco_registros : directed self-checking bench for banco_registros
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_banco_registros;
  import banco_pkg::*;

  localparam int WIDTH    = DEF_WIDTH;
  localparam int CHANNELS = DEF_CHANNELS;
  localparam int ADDR_W   = DEF_ADDR_W;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    data_in;
  logic                wr_ack;
  logic                wr_err;
  logic                snap;
  logic [ADDR_W-1:0]   rd_addr;
  logic                sel_shadow;
  logic [WIDTH-1:0]    data_out;
  logic [CHANNELS-1:0] dirty;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt;
  int ack_cycle;
  logic [WIDTH-1:0] exp_live [CHANNELS];

  banco_registros #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .data_in    (data_in),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .snap       (snap),
    .rd_addr    (rd_addr),
    .sel_shadow (sel_shadow),
    .data_out   (data_out),
    .dirty      (dirty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ch(input int addr, input logic [WIDTH-1:0] val);
    wr_req  = 1'b1;
    wr_addr = ADDR_W'(addr);
    data_in = val;
    tick();
    wr_req  = 1'b0;
    tick();
  endtask

  task automatic read_ch(input int addr, input logic sh, output logic [WIDTH-1:0] val);
    rd_addr    = ADDR_W'(addr);
    sel_shadow = sh;
    tick();
    val = data_out;
  endtask

  logic [WIDTH-1:0] rv;

  initial begin
    reset_n = 1'b0; wr_req = 1'b0; wr_addr = '0; data_in = '0;
    snap = 1'b0; rd_addr = '0; sel_shadow = 1'b0;
    tick(); tick();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_dirty",    32'(dirty),    32'h0);
    check("rst_wr_ack",   32'(wr_ack),   32'h0);
    check("rst_wr_err",   32'(wr_err),   32'h0);
    reset_n = 1'b1;
    tick();

    // 1: reset while wr_ack is high
    wr_req = 1'b1; wr_addr = ADDR_W'(CH_SEG); data_in = 8'h59;
    tick();
    check("t1_ack_before_rst", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t1_rst_data_out", 32'(data_out), 32'h0);
    check("t1_rst_dirty",    32'(dirty),    32'h0);
    check("t1_rst_wr_ack",   32'(wr_ack),   32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    read_ch(CH_SEG, 1'b0, rv);
    check("t1_live_ch0", 32'(rv), 32'h00);

    // 2: held write request acknowledges once
    wr_req = 1'b1; wr_addr = ADDR_W'(CH_MIN); data_in = 8'h45;
    ack_cnt = 0; ack_cycle = -1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (wr_ack) begin
        ack_cnt++;
        if (ack_cycle < 0) ack_cycle = c + 2;
      end
    end
    wr_req = 1'b0;
    tick();
    check("t2_ack_count", 32'(ack_cnt),   32'd1);
    check("t2_ack_cycle", 32'(ack_cycle), 32'd2);
    read_ch(CH_MIN, 1'b0, rv);
    check("t2_live_ch1", 32'(rv), 32'h45);
    check("t2_dirty", 32'(dirty), 32'b000000010);

    // 3: snapshot coherence
    write_ch(CH_SEG, 8'h30);
    write_ch(CH_MIN, 8'h12);
    snap = 1'b1; tick(); snap = 1'b0;
    check("t3_dirty_after_snap", 32'(dirty), 32'h0);
    write_ch(CH_SEG, 8'h31);
    read_ch(CH_SEG, 1'b1, rv);
    check("t3_shadow_ch0", 32'(rv), 32'h30);
    read_ch(CH_MIN, 1'b1, rv);
    check("t3_shadow_ch1", 32'(rv), 32'h12);
    read_ch(CH_SEG, 1'b0, rv);
    check("t3_live_ch0", 32'(rv), 32'h31);
    check("t3_dirty", 32'(dirty), 32'b000000001);

    // 4: write and snap on the same edge
    write_ch(CH_HORA, 8'h08);
    wr_req = 1'b1; wr_addr = ADDR_W'(CH_HORA); data_in = 8'h09; snap = 1'b1;
    tick();
    wr_req = 1'b0; snap = 1'b0;
    tick();
    check("t4_dirty", 32'(dirty), 32'b000000100);
    read_ch(CH_HORA, 1'b1, rv);
    check("t4_shadow_ch2", 32'(rv), 32'h08);
    read_ch(CH_HORA, 1'b0, rv);
    check("t4_live_ch2", 32'(rv), 32'h09);

    // 5: out-of-range write and read
    wr_req = 1'b1; wr_addr = ADDR_W'(12); data_in = 8'hFF;
    tick();
    check("t5_wr_err_pulse", 32'(wr_err), 32'h1);
    check("t5_wr_ack_low",   32'(wr_ack), 32'h0);
    tick();
    check("t5_wr_err_held_req", 32'(wr_err), 32'h0);
    wr_req = 1'b0;
    tick();
    check("t5_wr_err_end", 32'(wr_err), 32'h0);
    check("t5_dirty", 32'(dirty), 32'b000000100);
    read_ch(12, 1'b0, rv);
    check("t5_rd_oor_live", 32'(rv), 32'h00);
    read_ch(12, 1'b1, rv);
    check("t5_rd_oor_shadow", 32'(rv), 32'h00);
    for (int i = 0; i < CHANNELS; i++) exp_live[i] = '0;
    exp_live[CH_SEG]  = 8'h31;
    exp_live[CH_MIN]  = 8'h12;
    exp_live[CH_HORA] = 8'h09;
    for (int i = 0; i < CHANNELS; i++) begin
      read_ch(i, 1'b0, rv);
      check($sformatf("t5_live_ch%0d", i), 32'(rv), 32'(exp_live[i]));
    end

    // 6: read-before-write on the live bank
    write_ch(CH_DIA, 8'h15);
    rd_addr = ADDR_W'(CH_DIA); sel_shadow = 1'b0;
    wr_req = 1'b1; wr_addr = ADDR_W'(CH_DIA); data_in = 8'h16;
    tick();
    check("t6_rbw_old", 32'(data_out), 32'h15);
    wr_req = 1'b0;
    tick();
    check("t6_rbw_new", 32'(data_out), 32'h16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
